game_state_ctrl: RTL and testbench
==================================

// Module: game_state_ctrl
// PURPOSE
//  Top-level game sequencer. Owns the 2-bit game state (INIT/GAME/WAIT) that
//  drives the VGA overlay renderer, which paints the message box only in WAIT.
//  Debounces the start button on frame ticks, times the WAIT message display,
//  counts rounds and emits a blink enable for the overlay.
// PARAMETERS
//  WAIT_FRAMES   180  frames WAIT is held before timing out to INIT (3 s @ 60 Hz)
//  DEB_FRAMES    3    consecutive frame_tick samples of start_btn=1 for a press
//  BLINK_FRAMES  30   frame_ticks per msg_blink half-period in WAIT
//  ROUND_W       4    width of round counter
// PORTS
//  clk          in   1        system/pixel clock
//  rst_n        in   1        reset, synchronous, active-low
//  frame_tick   in   1        1-cycle pulse per frame (vsync start), sync to clk
//  start_btn    in   1        raw push-button level, asynchronous
//  game_over    in   1        1-cycle pulse from game logic
//  state        out  2        0=INIT 1=GAME 2=WAIT (3 never driven)
//  game_en      out  1        1 while state==GAME
//  clear_req    out  1        1-cycle pulse on every entry into GAME
//  msg_blink    out  1        overlay enable phase; 0 outside WAIT
//  round        out  ROUND_W  current round, 0 in INIT
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=INIT, game_en=0, clear_req=0,
//   msg_blink=0, round=0, all counters and sync flops 0. Reset mid-WAIT or
//   mid-debounce discards all progress.
//  Debounce: start_btn through 2-flop sync. On frame_tick: sync=1 -> deb_cnt
//   saturating ++ to DEB_FRAMES; sync=0 -> deb_cnt=0. start_press = 1-cycle
//   pulse in the cycle deb_cnt transitions to DEB_FRAMES. Held button yields one
//   press; release (one frame_tick with sync=0) needed to re-arm.
//  All outputs registered; state changes on the clk edge after the trigger.
//  INIT: start_press -> GAME, round<=1, clear_req=1 for one cycle.
//  GAME: game_over -> WAIT, wait_cnt<=WAIT_FRAMES, blink_cnt<=0, msg_blink<=1.
//   start_press ignored. game_over & start_press same cycle: game_over wins.
//  WAIT: each frame_tick: wait_cnt--, blink_cnt++; blink_cnt==BLINK_FRAMES-1
//   -> blink_cnt<=0, msg_blink toggles.
//   frame_tick with wait_cnt==1 -> INIT, round<=0, msg_blink<=0.
//   start_press -> GAME, round<=round+1 (saturate at 2^ROUND_W-1),
//   clear_req pulse, msg_blink<=0. start_press and timeout same cycle:
//   start_press wins.
//  game_over outside GAME ignored. frame_tick absent -> WAIT holds forever.
//  state==3 (upset) -> INIT next cycle, round<=0.
//  game_en = (state==GAME), registered with state, never a cycle apart.
//  wait_cnt width = $clog2(WAIT_FRAMES+1); blink_cnt = $clog2(BLINK_FRAMES).
// STRUCTURE
//  Shared package game_pkg: state encodings ST_INIT=2'd0, ST_GAME=2'd1,
//   ST_WAIT=2'd2 and state width; used by this block and overlay renderer.
//  One sub-module: btn_debounce (2-flop sync + frame-tick counter + press
//   pulse), params DEB_FRAMES. Everything else inline in one FSM process.
// TESTING  (bench: WAIT_FRAMES=5, DEB_FRAMES=3, BLINK_FRAMES=2, tick every 10 clk)
//  1 Reset: hold rst_n=0 3 clk with btn=1, game_over=1 -> state=0, round=0,
//    game_en=0, clear_req=0, msg_blink=0 on every cycle during/after reset.
//  2 Debounce: btn=1 for 2 ticks then 0 -> stays INIT; btn=1 for 3 ticks ->
//    one clear_req pulse, state=1, round=1; hold btn 10 more ticks -> no
//    further clear_req.
//  3 Timeout: in GAME pulse game_over -> state=2 next clk, msg_blink=1;
//    msg_blink toggles after ticks 2 and 4; after 5th tick state=0,
//    round=0, msg_blink=0.
//  4 Resume: in WAIT round=1, valid press -> state=1, round=2, clear_req
//    pulse; press coincident with 5th tick -> GAME (press wins).
//  5 Conflicts: game_over and start_press same cycle in GAME -> WAIT;
//    game_over in INIT/WAIT -> no change; round at 15 + resume -> stays 15.
//  6 Reset mid-WAIT (wait_cnt=3) -> INIT, all outputs at reset values;
//    force state=3 -> INIT one clk later.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: game state encodings shared by the sequencer and overlay renderer.
package game_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_INIT = 2'd0,
      ST_GAME = 2'd1,
      ST_WAIT = 2'd2
   } game_state_t;

endpackage

// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: game-logic inputs and overlay-facing state outputs.
interface game_state_ctrl_if #(
   parameter int ROUND_W = 4
);

   logic                         frame_tick;
   logic                         start_btn;
   logic                         game_over;
   logic [game_pkg::STATE_W-1:0] state;
   logic                         game_en;
   logic                         clear_req;
   logic                         msg_blink;
   logic [ROUND_W-1:0]           round;

   modport master (
      output frame_tick,
      output start_btn,
      output game_over,
      input  state,
      input  game_en,
      input  clear_req,
      input  msg_blink,
      input  round
   );

   modport slave (
      input  frame_tick,
      input  start_btn,
      input  game_over,
      output state,
      output game_en,
      output clear_req,
      output msg_blink,
      output round
   );

endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, frame-tick sample counter and a
// single-cycle press pulse once the button has been high DEB_FRAMES ticks.
module btn_debounce #(
   parameter int DEB_FRAMES = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   input  logic btn,
   output logic press
);

   localparam int CW = $clog2(DEB_FRAMES + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEB_FRAMES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_FRAMES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         press  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], btn};
         press  <= 1'b0;
         if (frame_tick) begin
            // saturating at full keeps a held button to one press
            if (!sync_q[1]) begin
               cnt_q <= '0;
            end else if (cnt_q != CNT_FULL) begin
               cnt_q <= cnt_q + 1'b1;
               press <= (cnt_q == CNT_LAST);
            end
         end
      end
   end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: INIT/GAME/WAIT sequencer for the overlay renderer with
// debounced start, timed WAIT message, blink phase and round counter.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int WAIT_FRAMES  = 180,
   parameter int DEB_FRAMES   = 3,
   parameter int BLINK_FRAMES = 30,
   parameter int ROUND_W      = 4
) (
   input logic              clk,
   input logic              rst_n,
   game_state_ctrl_if.slave bus
);

   localparam int WW = $clog2(WAIT_FRAMES + 1);
   localparam int BW =
      (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_FRAMES);
   localparam logic [WW-1:0] WAIT_LAST = WW'(1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [ROUND_W-1:0] ROUND_MAX = '1;
   localparam logic [ROUND_W-1:0] ROUND_ONE = ROUND_W'(1);

   game_state_t        state_q;
   logic               game_en_q;
   logic               clear_q;
   logic               blink_q;
   logic [ROUND_W-1:0] round_q;
   logic [WW-1:0]      wait_q;
   logic [BW-1:0]      bcnt_q;
   logic               start_press;

   btn_debounce #(
      .DEB_FRAMES(DEB_FRAMES)
   ) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (bus.frame_tick),
      .btn        (bus.start_btn),
      .press      (start_press)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_INIT;
         game_en_q <= 1'b0;
         clear_q   <= 1'b0;
         blink_q   <= 1'b0;
         round_q   <= '0;
         wait_q    <= '0;
         bcnt_q    <= '0;
      end else begin
         clear_q <= 1'b0;
         unique case (state_q)
            ST_INIT: begin
               if (start_press) begin
                  state_q   <= ST_GAME;
                  game_en_q <= 1'b1;
                  round_q   <= ROUND_ONE;
                  clear_q   <= 1'b1;
               end
            end
            ST_GAME: begin
               if (bus.game_over) begin
                  state_q   <= ST_WAIT;
                  game_en_q <= 1'b0;
                  wait_q    <= WAIT_INIT;
                  bcnt_q    <= '0;
                  blink_q   <= 1'b1;
               end
            end
            ST_WAIT: begin
               // a resume press outranks a coincident timeout
               if (start_press) begin
                  state_q   <= ST_GAME;
                  game_en_q <= 1'b1;
                  clear_q   <= 1'b1;
                  blink_q   <= 1'b0;
                  if (round_q != ROUND_MAX) begin
                     round_q <= round_q + 1'b1;
                  end
               end else if (bus.frame_tick) begin
                  if (wait_q == WAIT_LAST) begin
                     state_q <= ST_INIT;
                     round_q <= '0;
                     blink_q <= 1'b0;
                  end else begin
                     wait_q <= wait_q - 1'b1;
                     if (bcnt_q == BLINK_LAST) begin
                        bcnt_q  <= '0;
                        blink_q <= ~blink_q;
                     end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q   <= ST_INIT;
               game_en_q <= 1'b0;
               blink_q   <= 1'b0;
               round_q   <= '0;
            end
         endcase
      end
   end

   assign bus.state     = state_q;
   assign bus.game_en   = game_en_q;
   assign bus.clear_req = clear_q;
   assign bus.msg_blink = blink_q;
   assign bus.round     = round_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: table rows, corner sequences and random stimulus
// checked every cycle against a frame-level model of the game rules.
module tb_game_state_ctrl;
   import game_pkg::*;

   localparam int WAIT_F  = 5;
   localparam int DEB_F   = 3;
   localparam int BLINK_F = 2;
   localparam int ROUND_W = 4;
   localparam int RMAX    = (1 << ROUND_W) - 1;
   localparam int FRAME   = 10;
   localparam int TICK_AT = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   game_state_ctrl_if #(.ROUND_W(ROUND_W)) bus ();

   game_state_ctrl #(
      .WAIT_FRAMES  (WAIT_F),
      .DEB_FRAMES   (DEB_F),
      .BLINK_FRAMES (BLINK_F),
      .ROUND_W      (ROUND_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_clr = 0;

   // model: mode 0/1/2, frames elapsed in WAIT, run of high samples
   int m_mode, m_round, m_elapsed, m_run;
   bit m_sh0, m_sh1, m_press, m_clear;

   typedef struct {
      bit btn;
      bit go;
      int nfr;
      int st;
      int rnd;
      int blk;
      int clr;
   } row_t;

   row_t tbl [14];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_round = 0; m_elapsed = 0; m_run = 0;
      m_sh0 = 0; m_sh1 = 0; m_press = 0; m_clear = 0;
   endtask

   task automatic model_edge(input bit tick, input bit go,
                             input bit btn);
      bit s;
      bit np;
      s = m_sh1;
      m_sh1 = m_sh0;
      m_sh0 = btn;
      np = 0;
      if (tick) begin
         if (s) begin
            m_run++;
            if (m_run == DEB_F) np = 1;
         end else begin
            m_run = 0;
         end
      end
      m_clear = 0;
      case (m_mode)
         0: if (m_press) begin
            m_mode = 1; m_round = 1; m_clear = 1;
         end
         1: if (go) begin
            m_mode = 2; m_elapsed = 0;
         end
         default: begin
            if (m_press) begin
               m_mode = 1; m_clear = 1;
               m_round = (m_round < RMAX) ? m_round + 1 : RMAX;
            end else if (tick) begin
               m_elapsed++;
               if (m_elapsed == WAIT_F) begin
                  m_mode = 0; m_round = 0;
               end
            end
         end
      endcase
      m_press = np;
   endtask

   function automatic int exp_blink();
      return (m_mode == 2 && ((m_elapsed / BLINK_F) % 2) == 0) ? 1 : 0;
   endfunction

   task automatic check_all();
      chk("state", int'(bus.state), m_mode);
      chk("game_en", int'(bus.game_en), (m_mode == 1) ? 1 : 0);
      chk("clear_req", int'(bus.clear_req), int'(m_clear));
      chk("msg_blink", int'(bus.msg_blink), exp_blink());
      chk("round", int'(bus.round), m_round);
   endtask

   task automatic step(input bit tick, input bit go);
      bus.frame_tick = tick;
      bus.game_over  = go;
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(tick, go, bus.start_btn);
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.game_over  = 1'b0;
      check_all();
      n_clr += int'(bus.clear_req);
   endtask

   task automatic frames(input int n, input bit go);
      for (int f = 0; f < n; f++)
         for (int c = 0; c < FRAME; c++)
            step(c == TICK_AT, go && f == 0 && c == 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   // button high for three spaced ticks; press pulse lands after the last
   task automatic arm_press();
      bus.start_btn = 1'b1;
      idle(4);
      step(1'b1, 1'b0);
      idle(2);
      step(1'b1, 1'b0);
      idle(2);
      step(1'b1, 1'b0);
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.start_btn  = 1'b1;
      bus.game_over  = 1'b1;
      model_reset();

      //           btn go nfr st rnd blk clr
      tbl[0]  = '{1, 0, 2,  0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1,  0, 0, 0, 0};
      tbl[2]  = '{1, 0, 3,  1, 1, 0, 1};
      tbl[3]  = '{1, 0, 10, 1, 1, 0, 0};
      tbl[4]  = '{0, 1, 1,  2, 1, 1, 0};
      tbl[5]  = '{0, 0, 1,  2, 1, 0, 0};
      tbl[6]  = '{0, 0, 2,  2, 1, 1, 0};
      tbl[7]  = '{0, 0, 1,  0, 0, 0, 0};
      tbl[8]  = '{1, 0, 3,  1, 1, 0, 1};
      tbl[9]  = '{0, 1, 1,  2, 1, 1, 0};
      tbl[10] = '{1, 0, 3,  1, 2, 0, 1};
      tbl[11] = '{0, 1, 1,  2, 2, 1, 0};
      tbl[12] = '{0, 1, 4,  0, 0, 0, 0};
      tbl[13] = '{0, 1, 1,  0, 0, 0, 0};

      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      rst_n = 1'b1;
      bus.start_btn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1);
         chk("post_rst.state", int'(bus.state), 0);
      end

      foreach (tbl[i]) begin
         bus.start_btn = tbl[i].btn;
         n_clr = 0;
         frames(tbl[i].nfr, tbl[i].go);
         chk($sformatf("row%0d.state", i), int'(bus.state), tbl[i].st);
         chk($sformatf("row%0d.round", i), int'(bus.round), tbl[i].rnd);
         chk($sformatf("row%0d.blink", i),
             int'(bus.msg_blink), tbl[i].blk);
         chk($sformatf("row%0d.clears", i), n_clr, tbl[i].clr);
      end

      // press lands on the same edge as the fifth WAIT tick
      bus.start_btn = 1'b1;
      frames(3, 1'b0);
      bus.start_btn = 1'b0;
      frames(1, 1'b1);
      arm_press();
      step(1'b1, 1'b0);
      chk("coinc.state", int'(bus.state), 1);
      chk("coinc.round", int'(bus.round), 2);
      chk("coinc.clear", int'(bus.clear_req), 1);

      // game_over and start_press on the same edge in GAME
      bus.start_btn = 1'b0;
      frames(1, 1'b0);
      arm_press();
      step(1'b0, 1'b1);
      chk("conflict.state", int'(bus.state), 2);
      chk("conflict.round", int'(bus.round), 2);

      // resume repeatedly until the round counter saturates
      bus.start_btn = 1'b0;
      frames(1, 1'b0);
      bus.start_btn = 1'b1;
      frames(3, 1'b0);
      chk("resume.round", int'(bus.round), 3);
      for (int k = 0; k < 13; k++) begin
         bus.start_btn = 1'b0;
         frames(1, 1'b1);
         bus.start_btn = 1'b1;
         n_clr = 0;
         frames(3, 1'b0);
      end
      chk("sat.round", int'(bus.round), RMAX);
      chk("sat.clears", n_clr, 1);
      chk("sat.state", int'(bus.state), 1);

      // reset with three WAIT frames still outstanding
      bus.start_btn = 1'b0;
      frames(1, 1'b1);
      frames(1, 1'b0);
      chk("midwait.state", int'(bus.state), 2);
      rst_n = 1'b0;
      step(1'b1, 1'b0);
      chk("rst_wait.state", int'(bus.state), 0);
      chk("rst_wait.round", int'(bus.round), 0);
      chk("rst_wait.blink", int'(bus.msg_blink), 0);
      rst_n = 1'b1;
      frames(2, 1'b0);
      chk("after_rst.state", int'(bus.state), 0);

      // upset state encoding recovers to INIT
      bus.start_btn = 1'b1;
      frames(3, 1'b0);
      chk("pre_upset.state", int'(bus.state), 1);
      force dut.state_q = game_state_t'(2'd3);
      @(posedge clk);
      #1;
      release dut.state_q;
      @(negedge clk);
      m_mode  = 0;
      m_round = 0;
      m_clear = 0;
      step(1'b0, 1'b0);
      chk("upset.state", int'(bus.state), 0);
      chk("upset.round", int'(bus.round), 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0)
            bus.start_btn = ~bus.start_btn;
         rst_n = ($urandom_range(0, 399) != 0);
         step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
